// File: rtl/display_pkg.sv
// Shared constants for the CPU output hex display: digit geometry and
// active-low seven-segment patterns ({g,f,e,d,c,b,a}).
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIG_W      = $clog2(NUM_DIGITS);
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned DATA_W     = NUM_DIGITS * NIB_W;
  localparam int unsigned UPD_W      = 8;

  localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = 4'hF;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

  // Active-low one-hot anode enable for a digit index.
  function automatic logic [NUM_DIGITS-1:0] digit_enable(input logic [DIG_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] pattern_c
);

  always_comb begin
    pattern_c = SEG_BLANK;
    case (nibble)
      4'h0: pattern_c = SEG_0;
      4'h1: pattern_c = SEG_1;
      4'h2: pattern_c = SEG_2;
      4'h3: pattern_c = SEG_3;
      4'h4: pattern_c = SEG_4;
      4'h5: pattern_c = SEG_5;
      4'h6: pattern_c = SEG_6;
      4'h7: pattern_c = SEG_7;
      4'h8: pattern_c = SEG_8;
      4'h9: pattern_c = SEG_9;
      4'hA: pattern_c = SEG_A;
      4'hB: pattern_c = SEG_B;
      4'hC: pattern_c = SEG_C;
      4'hD: pattern_c = SEG_D;
      4'hE: pattern_c = SEG_E;
      4'hF: pattern_c = SEG_F;
      default: pattern_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/cpu_out_hex_display.sv
// Captures the CPU out bus and scans it onto a 4-digit common-anode
// seven-segment display; also counts value changes for a debug LED.
module cpu_out_hex_display
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          LZ_BLANK    = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic [SEG_W-1:0]  seg,
  output logic              dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic [UPD_W-1:0]  update_count
);

  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

  logic [DATA_W-1:0] disp_q;
  logic [REF_W-1:0]  refresh_cnt;
  logic [DIG_W-1:0]  digit_idx;

  logic [NIB_W-1:0]  nibble_c;
  logic [DATA_W-1:0] upper_c;
  logic              blank_c;
  logic [SEG_W-1:0]  pattern_c;
  logic              wrap_c;

  assign dp     = 1'b1;
  assign wrap_c = (refresh_cnt == REF_LAST);

  // Capture register and saturating change counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_q       <= '0;
      update_count <= '0;
    end else if (data_valid) begin
      disp_q <= data_in;
      if ((data_in != disp_q) && (update_count != '1)) begin
        update_count <= update_count + UPD_W'(1);
      end
    end
  end

  // Refresh timer and digit scan index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (wrap_c) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + DIG_W'(1);
    end else begin
      refresh_cnt <= refresh_cnt + REF_W'(1);
    end
  end

  // Digit mux; a digit is a leading zero when it and everything above it is zero.
  always_comb begin
    nibble_c = disp_q[NIB_W * 32'(digit_idx) +: NIB_W];
    upper_c  = disp_q >> (NIB_W * 32'(digit_idx));
    blank_c  = LZ_BLANK && (digit_idx != '0) && (upper_c == '0);
  end

  hex_to_seg7 u_dec (
    .nibble    (nibble_c),
    .pattern_c (pattern_c)
  );

  // seg and an share one register stage so a digit switch is glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg <= SEG_BLANK;
      an  <= AN_OFF;
    end else if (blank_c) begin
      seg <= SEG_BLANK;
      an  <= AN_OFF;
    end else begin
      seg <= pattern_c;
      an  <= digit_enable(digit_idx);
    end
  end

endmodule

// File: tb/tb_cpu_out_hex_display.sv
// Directed bench for cpu_out_hex_display using three instances:
// REFRESH_DIV=4 plain, REFRESH_DIV=4 with leading-zero blanking, REFRESH_DIV=1.
module tb_cpu_out_hex_display;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        reset;
  logic [15:0] data_in;
  logic        data_valid;

  logic [6:0] seg, seg_lz, seg_f;
  logic       dp, dp_lz, dp_f;
  logic [3:0] an, an_lz, an_f;
  logic [7:0] cnt, cnt_lz, cnt_f;

  int pass_cnt = 0;
  int check_cnt = 0;

  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  cpu_out_hex_display #(.REFRESH_DIV(4), .LZ_BLANK(1'b0)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .seg(seg), .dp(dp), .an(an), .update_count(cnt));

  cpu_out_hex_display #(.REFRESH_DIV(4), .LZ_BLANK(1'b1)) dut_lz (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .seg(seg_lz), .dp(dp_lz), .an(an_lz), .update_count(cnt_lz));

  cpu_out_hex_display #(.REFRESH_DIV(1), .LZ_BLANK(1'b0)) dut_f (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .seg(seg_f), .dp(dp_f), .an(an_f), .update_count(cnt_f));

  always #5 if (clk_en) clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset all instances, then release just after an edge so the next edge is edge 1.
  task automatic start(input logic [15:0] v);
    reset = 1'b0;
    data_valid = 1'b1;
    data_in = v;
    step();
    step();
    reset = 1'b1;
  endtask

  function automatic logic [3:0] nib(input logic [15:0] v, input int d);
    logic [15:0] s;
    s = v >> (4 * d);
    return s[3:0];
  endfunction

  function automatic logic [3:0] en(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    data_valid = 1'b1;
    data_in = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      check_cnt++;
      if ({seg, an, dp, cnt} !== {7'h7F, 4'hF, 1'b1, 8'h00})
        $display("FAIL reset_clk[%0d]: got seg=%h an=%h dp=%b cnt=%h want 7f f 1 00", i, seg, an, dp, cnt);
      else pass_cnt++;
    end
    reset = 1'b1;
    step();
    check_cnt++;
    if ({seg, an} !== {7'h40, 4'hE})
      $display("FAIL first_digit: got seg=%h an=%h want 40 e", seg, an);
    else pass_cnt++;
    step();
    check_cnt++;
    if ({seg, an} !== {7'h0E, 4'hE})
      $display("FAIL post_capture: got seg=%h an=%h want 0e e", seg, an);
    else pass_cnt++;
    // Reset with the clock stopped must still clear everything.
    clk_en = 1'b0;
    #1 reset = 1'b0;
    #1;
    check_cnt++;
    if ({seg, an, dp, cnt} !== {7'h7F, 4'hF, 1'b1, 8'h00})
      $display("FAIL reset_noclk: got seg=%h an=%h dp=%b cnt=%h want 7f f 1 00", seg, an, dp, cnt);
    else pass_cnt++;
    #30;
    check_cnt++;
    if ({seg, an, dp, cnt} !== {7'h7F, 4'hF, 1'b1, 8'h00})
      $display("FAIL reset_noclk_hold: got seg=%h an=%h dp=%b cnt=%h want 7f f 1 00", seg, an, dp, cnt);
    else pass_cnt++;
    clk_en = 1'b1;
    step();
  endtask

  task automatic test_scan();
    logic [6:0] es;
    logic [3:0] ea;
    int d;
    start(16'h12AF);
    for (int k = 1; k <= 20; k++) begin
      step();
      d = (k == 1) ? 0 : ((k - 1) / 4) % 4;
      es = (k == 1) ? 7'h40 : dec[nib(16'h12AF, d)];
      ea = en(d);
      check_cnt++;
      if ({seg, an, dp} !== {es, ea, 1'b1})
        $display("FAIL scan[k=%0d]: got seg=%h an=%h dp=%b want %h %h 1", k, seg, an, dp, es, ea);
      else pass_cnt++;
    end
  endtask

  task automatic test_decode();
    logic [15:0] vals [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    logic [6:0] es;
    logic [3:0] ea;
    int d;
    for (int v = 0; v < 4; v++) begin
      start(vals[v]);
      step();
      for (int k = 2; k <= 5; k++) begin
        step();
        d = (k - 1) % 4;
        es = dec[nib(vals[v], d)];
        ea = en(d);
        check_cnt++;
        if ({seg_f, an_f} !== {es, ea})
          $display("FAIL decode[%h d%0d]: got seg=%h an=%h want %h %h", vals[v], d, seg_f, an_f, es, ea);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_change_counter();
    logic [15:0] seq [5] = '{16'h0001, 16'h0001, 16'h0002, 16'h0002, 16'h0003};
    start(16'h0000);
    for (int i = 0; i < 5; i++) begin
      data_in = seq[i];
      step();
      if (i == 1) begin
        check_cnt++;
        if (cnt !== 8'h01) $display("FAIL cnt_recapture: got %h want 01", cnt);
        else pass_cnt++;
      end
    end
    check_cnt++;
    if (cnt !== 8'h03) $display("FAIL cnt_seq: got %h want 03", cnt);
    else pass_cnt++;
    for (int i = 0; i < 300; i++) begin
      data_in = 16'h1000 + 16'(i);
      step();
      if (i == 200) begin
        check_cnt++;
        if (cnt !== 8'hCC) $display("FAIL cnt_mid: got %h want cc", cnt);
        else pass_cnt++;
      end
    end
    check_cnt++;
    if (cnt !== 8'hFF) $display("FAIL cnt_saturate: got %h want ff", cnt);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    logic [6:0] es;
    logic [3:0] ea;
    int d;
    start(16'h4567);
    step();
    data_valid = 1'b0;
    for (int k = 2; k <= 9; k++) begin
      data_in = 16'($urandom);
      step();
      d = (k - 1) % 4;
      es = dec[nib(16'h4567, d)];
      ea = en(d);
      check_cnt++;
      if ({seg_f, an_f} !== {es, ea})
        $display("FAIL hold[k=%0d]: got seg=%h an=%h want %h %h", k, seg_f, an_f, es, ea);
      else pass_cnt++;
    end
    check_cnt++;
    if (cnt !== 8'h01) $display("FAIL hold_count: got %h want 01", cnt);
    else pass_cnt++;
    data_valid = 1'b1;
  endtask

  task automatic test_blanking();
    int         ks [4] = '{2, 5, 9, 13};
    logic [6:0] s50 [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    logic [3:0] a50 [4] = '{4'hE, 4'hD, 4'hF, 4'hF};
    logic [6:0] s00 [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    logic [3:0] a00 [4] = '{4'hE, 4'hF, 4'hF, 4'hF};
    int j;
    start(16'h0050);
    j = 0;
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k == ks[j]) begin
        check_cnt++;
        if ({seg_lz, an_lz} !== {s50[j], a50[j]})
          $display("FAIL blank50[slot%0d]: got seg=%h an=%h want %h %h", j, seg_lz, an_lz, s50[j], a50[j]);
        else pass_cnt++;
        if (j == 2) begin
          check_cnt++;
          if ({seg, an} !== {7'h40, 4'hB})
            $display("FAIL noblank50[slot2]: got seg=%h an=%h want 40 b", seg, an);
          else pass_cnt++;
        end
        if (j < 3) j++;
      end
    end
    start(16'h0000);
    j = 0;
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k == ks[j]) begin
        check_cnt++;
        if ({seg_lz, an_lz} !== {s00[j], a00[j]})
          $display("FAIL blank00[slot%0d]: got seg=%h an=%h want %h %h", j, seg_lz, an_lz, s00[j], a00[j]);
        else pass_cnt++;
        if (j < 3) j++;
      end
    end
  endtask

  task automatic test_capture_at_wrap();
    start(16'h12AF);
    for (int k = 1; k <= 3; k++) step();
    data_in = 16'h00C0;
    step();
    check_cnt++;
    if ({seg, an} !== {7'h0E, 4'hE})
      $display("FAIL wrap_edge: got seg=%h an=%h want 0e e", seg, an);
    else pass_cnt++;
    step();
    check_cnt++;
    if ({seg, an, cnt} !== {7'h46, 4'hD, 8'h02})
      $display("FAIL wrap_after: got seg=%h an=%h cnt=%h want 46 d 02", seg, an, cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_scan();
    start(16'h12AF);
    for (int k = 1; k <= 9; k++) step();
    check_cnt++;
    if ({seg, an} !== {7'h24, 4'hB})
      $display("FAIL midscan_pre: got seg=%h an=%h want 24 b", seg, an);
    else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    check_cnt++;
    if ({seg, an, dp, cnt} !== {7'h7F, 4'hF, 1'b1, 8'h00})
      $display("FAIL midscan_async: got seg=%h an=%h dp=%b cnt=%h want 7f f 1 00", seg, an, dp, cnt);
    else pass_cnt++;
    data_in = 16'h7654;
    step();
    reset = 1'b1;
    step();
    check_cnt++;
    if ({seg, an} !== {7'h40, 4'hE})
      $display("FAIL midscan_restart: got seg=%h an=%h want 40 e", seg, an);
    else pass_cnt++;
    step();
    check_cnt++;
    if ({seg, an} !== {7'h19, 4'hE})
      $display("FAIL midscan_value: got seg=%h an=%h want 19 e", seg, an);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b0;
    data_in = '0;
    data_valid = 1'b0;
    test_reset();
    test_scan();
    test_decode();
    test_change_counter();
    test_hold();
    test_blanking();
    test_capture_at_wrap();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
